// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the data-memory bus.
//   - Access width encodings carried on data_width.
//   - Responder state encoding.
//   - Lane helpers: byte-enable generation, write-data replication and
//     read-data right-alignment with zero extension.
package riscv_bus_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte enables for an (already aligned) access at byte offset 'offset'.
  function automatic logic [3:0] lane_enable(input logic [1:0] width,
                                             input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: return 4'b0001 << offset;
      WIDTH_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it may land in.
  function automatic logic [31:0] lane_data(input logic [1:0]  width,
                                            input logic [31:0] wdata);
    case (width)
      WIDTH_BYTE: return {4{wdata[7:0]}};
      WIDTH_HALF: return {2{wdata[15:0]}};
      default:    return wdata;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0 and zero the rest.
  function automatic logic [31:0] lane_extract(input logic [1:0]  width,
                                               input logic [1:0]  offset,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (width)
      WIDTH_BYTE: return {24'h0, shifted[7:0]};
      WIDTH_HALF: return {16'h0, shifted[15:0]};
      default:    return shifted;
    endcase
  endfunction

endpackage

// File: rtl/riscv_byte_lane_ram.sv
// Word-organised storage with per-byte write enables.
//   clock        : single clock, rising edge
//   write_enable : one bit per byte lane
//   write_index  : word index for the write port
//   write_data   : lane-replicated write data
//   read_enable  : load read_data on this edge
//   read_index   : word index for the read port
//   read_data    : registered read word; holds while read_enable is low
// Contents are never cleared.
module riscv_byte_lane_ram #(
  parameter int unsigned INDEX_WIDTH = 10
) (
  input  logic                   clock,
  input  logic [3:0]             write_enable,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [31:0]            write_data,
  input  logic                   read_enable,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [31:0]            read_data
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (write_enable[i]) begin
        mem[write_index][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
    if (read_enable) begin
      read_data <= mem[read_index];
    end
  end

endmodule

// File: rtl/riscv_data_memory.sv
// Data memory responder for a RISC-V core with configurable wait states.
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   data_address : byte address (bits above ADDR_WIDTH-1 ignored)
//   data_width   : 0 byte, 1 half, 2 word, 3 invalid
//   data_out     : right-aligned store data
//   data_read    : load request
//   data_write   : store request (wins when both are set)
//   data_in      : right-aligned, zero-extended load data
//   data_ready   : one-cycle response strobe
//   data_error   : fault flag, meaningful only with data_ready
// Build option: RISCV_DMEM_MISALIGN_ERR_EN reports misaligned/invalid
// accesses as errors; without it offending address bits are cleared and
// width 3 behaves as word.
module riscv_data_memory
  import riscv_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        data_ready,
  output logic        data_error
);

  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t state, next_state;
  logic [3:0] count;

  logic unused_high_address;
  assign unused_high_address = ^data_address[31:ADDR_WIDTH];

  // Request as seen on the bus, normalised for the selected build.
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_width;
  logic                  req_fault;

  always_comb begin
    req_addr  = data_address[ADDR_WIDTH-1:0];
    req_width = data_width;
    req_fault = 1'b0;
`ifdef RISCV_DMEM_MISALIGN_ERR_EN
    case (data_width)
      WIDTH_BYTE: req_fault = 1'b0;
      WIDTH_HALF: req_fault = data_address[0];
      WIDTH_WORD: req_fault = |data_address[1:0];
      default:    req_fault = 1'b1;
    endcase
`else
    case (data_width)
      WIDTH_BYTE: req_addr = data_address[ADDR_WIDTH-1:0];
      WIDTH_HALF: req_addr[0] = 1'b0;
      default: begin
        req_width     = WIDTH_WORD;
        req_addr[1:0] = 2'b00;
      end
    endcase
`endif
  end

  logic request, accept;
  assign request = data_read | data_write;
  // Requests during WAIT are retries of the pending access.
  assign accept  = request && (state == IDLE || state == RESP);

  // Pending access, used when the commit happens after wait states.
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [1:0]            pend_width;
  logic [31:0]           pend_wdata;
  logic                  pend_write;
  logic                  pend_fault;

  always_ff @(posedge clock) begin
    if (accept) begin
      pend_addr  <= req_addr;
      pend_width <= req_width;
      pend_wdata <= data_out;
      pend_write <= data_write;
      pend_fault <= req_fault;
    end
  end

  // The memory access happens on the edge entering RESP: from the live bus
  // when there are no wait states, otherwise from the pending registers.
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [1:0]            acc_width;
  logic [31:0]           acc_wdata;
  logic                  acc_write;
  logic                  acc_fault;
  logic                  do_access;

  always_comb begin
    acc_addr  = req_addr;
    acc_width = req_width;
    acc_wdata = data_out;
    acc_write = data_write;
    acc_fault = req_fault;
    if (state == WAIT) begin
      acc_addr  = pend_addr;
      acc_width = pend_width;
      acc_wdata = pend_wdata;
      acc_write = pend_write;
      acc_fault = pend_fault;
    end
  end

  // Reset suppresses the commit, discarding an accepted write.
  assign do_access = !reset &&
                     ((accept && NO_WAIT) || (state == WAIT && count == 4'd1));

  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign ram_we = (do_access && acc_write && !acc_fault)
                ? lane_enable(acc_width, acc_addr[1:0]) : '0;
  assign ram_re = do_access && !acc_write && !acc_fault;

  riscv_byte_lane_ram #(
    .INDEX_WIDTH(ADDR_WIDTH - 2)
  ) u_ram (
    .clock       (clock),
    .write_enable(ram_we),
    .write_index (acc_addr[ADDR_WIDTH-1:2]),
    .write_data  (lane_data(acc_width, acc_wdata)),
    .read_enable (ram_re),
    .read_index  (acc_addr[ADDR_WIDTH-1:2]),
    .read_data   (ram_rdata)
  );

  // data_in is formed from the registered RAM word plus the registered lane
  // selection; resp_zero stands in for a cleared data_in register after
  // reset, write responses and faulting accesses.
  logic       resp_zero;
  logic [1:0] resp_offset;
  logic [1:0] resp_width;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_zero   <= 1'b1;
      resp_offset <= '0;
      resp_width  <= '0;
    end else if (do_access) begin
      if (acc_write || acc_fault) begin
        resp_zero <= 1'b1;
      end else begin
        resp_zero   <= 1'b0;
        resp_offset <= acc_addr[1:0];
        resp_width  <= acc_width;
      end
    end
  end

`ifdef RISCV_DMEM_MISALIGN_ERR_EN
  logic resp_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_error <= 1'b0;
    end else if (do_access) begin
      resp_error <= acc_fault;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (accept && !NO_WAIT) begin
      count <= WAIT_INIT;
    end else if (state == WAIT) begin
      count <= count - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          next_state = NO_WAIT ? RESP : WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (count == 4'd1) begin
          next_state = RESP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    data_ready = (state == RESP);
`ifdef RISCV_DMEM_MISALIGN_ERR_EN
    data_error = (state == RESP) && resp_error;
`else
    data_error = 1'b0;
`endif
    data_in = resp_zero ? '0 : lane_extract(resp_width, resp_offset, ram_rdata);
  end

endmodule

// File: tb/tb_riscv_data_memory.sv
// Directed bench for riscv_data_memory: dut0 has no wait states, dut1 has
// three. Expected values are hand-computed per step.
module tb_riscv_data_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  width [2];
  logic        rd    [2];
  logic        wr    [2];
  logic        ready [2];
  logic        err   [2];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  riscv_data_memory #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .data_address(addr[0]), .data_width(width[0]),
    .data_out(wdata[0]), .data_read(rd[0]), .data_write(wr[0]),
    .data_in(rdata[0]), .data_ready(ready[0]), .data_error(err[0])
  );

  riscv_data_memory #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut1 (
    .clock(clock), .reset(reset), .data_address(addr[1]), .data_width(width[1]),
    .data_out(wdata[1]), .data_read(rd[1]), .data_write(wr[1]),
    .data_in(rdata[1]), .data_ready(ready[1]), .data_error(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [1:0] wd,
                       input logic [31:0] a, input logic [31:0] d);
    rd[s] = r; wr[s] = w; width[s] = wd; addr[s] = a; wdata[s] = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Zero-wait-state transfer: response expected right after the edge.
  task automatic xfer0(input string tag, input logic r, input logic w, input logic [1:0] wd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input logic exp_err);
    drive(0, r, w, wd, a, d);
    tick();
    check({tag, ".ready"}, 32'(ready[0]), 32'd1);
    check({tag, ".error"}, 32'(err[0]), 32'(exp_err));
    check({tag, ".data"}, rdata[0], exp_data);
  endtask

  // Wait-state transfer with bounded wait for data_ready.
  task automatic xfer1(input string tag, input logic r, input logic w, input logic [1:0] wd,
                       input logic [31:0] a, input logic [31:0] d, input bit hold,
                       input logic [31:0] exp_data);
    int n;
    n = 0;
    drive(1, r, w, wd, a, d);
    do begin
      tick();
      n++;
      if (!hold) drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    end while (ready[1] !== 1'b1 && n < 12);
    check({tag, ".latency"}, 32'(n), 32'd4);
    check({tag, ".data"}, rdata[1], exp_data);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    check({tag, ".drop"}, 32'(ready[1]), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst.ready0", 32'(ready[0]), 32'd0);
    check("rst.error0", 32'(err[0]), 32'd0);
    check("rst.data0", rdata[0], 32'h0);
    check("rst.ready1", 32'(ready[1]), 32'd0);
    reset = 1'b0;

    // Zero wait states: store then load back-to-back.
    xfer0("sw10", 1'b0, 1'b1, 2'd2, 32'h10, 32'h11223344, 32'h0, 1'b0);
    xfer0("lw10", 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 32'h11223344, 1'b0);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    check("idle.ready", 32'(ready[0]), 32'd0);
    check("idle.hold", rdata[0], 32'h11223344);

    // Byte store into lane 3, only the low byte of data_out is used.
    xfer0("sb13", 1'b0, 1'b1, 2'd0, 32'h13, 32'hFFFFFFAB, 32'h0, 1'b0);
    xfer0("lbu13", 1'b1, 1'b0, 2'd0, 32'h13, 32'h0, 32'h000000AB, 1'b0);
    xfer0("lw10b", 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 32'hAB223344, 1'b0);
    xfer0("lhu12", 1'b1, 1'b0, 2'd1, 32'h12, 32'h0, 32'h0000AB22, 1'b0);
    xfer0("lbu10", 1'b1, 1'b0, 2'd0, 32'h10, 32'h0, 32'h00000044, 1'b0);

    // Address aliasing above bit 11.
    xfer0("sw1004", 1'b0, 1'b1, 2'd2, 32'h1004, 32'hCAFEF00D, 32'h0, 1'b0);
    xfer0("lw0004", 1'b1, 1'b0, 2'd2, 32'h0004, 32'h0, 32'hCAFEF00D, 1'b0);

    // Misaligned half store and invalid width.
    xfer0("sw20", 1'b0, 1'b1, 2'd2, 32'h20, 32'h12345678, 32'h0, 1'b0);
`ifdef RISCV_DMEM_MISALIGN_ERR_EN
    xfer0("sh21", 1'b0, 1'b1, 2'd1, 32'h21, 32'h1111BEEF, 32'h0, 1'b1);
    xfer0("lw20", 1'b1, 1'b0, 2'd2, 32'h20, 32'h0, 32'h12345678, 1'b0);
    xfer0("lhu20", 1'b1, 1'b0, 2'd1, 32'h20, 32'h0, 32'h00005678, 1'b0);
    xfer0("lw3_22", 1'b1, 1'b0, 2'd3, 32'h22, 32'h0, 32'h0, 1'b1);
`else
    xfer0("sh21", 1'b0, 1'b1, 2'd1, 32'h21, 32'h1111BEEF, 32'h0, 1'b0);
    xfer0("lw20", 1'b1, 1'b0, 2'd2, 32'h20, 32'h0, 32'h1234BEEF, 1'b0);
    xfer0("lhu20", 1'b1, 1'b0, 2'd1, 32'h20, 32'h0, 32'h0000BEEF, 1'b0);
    xfer0("lw3_22", 1'b1, 1'b0, 2'd3, 32'h22, 32'h0, 32'h1234BEEF, 1'b0);
`endif

    // Read and write together count as a write.
    xfer0("rw40", 1'b1, 1'b1, 2'd2, 32'h40, 32'h00000077, 32'h0, 1'b0);
    xfer0("lw40", 1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 32'h00000077, 1'b0);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    check("end0.ready", 32'(ready[0]), 32'd0);

    // Three wait states.
    xfer1("w.sw30", 1'b0, 1'b1, 2'd2, 32'h30, 32'h0BADF00D, 1'b0, 32'h0);
    xfer1("w.sw08", 1'b0, 1'b1, 2'd2, 32'h08, 32'hA5A50001, 1'b0, 32'h0);
    xfer1("w.lw08hold", 1'b1, 1'b0, 2'd2, 32'h08, 32'h0, 1'b1, 32'hA5A50001);

    // Reset during WAIT of a store aborts it.
    drive(1, 1'b0, 1'b1, 2'd2, 32'h30, 32'h00000055);
    tick();
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    check("abort.wait1", 32'(ready[1]), 32'd0);
    tick();
    check("abort.wait2", 32'(ready[1]), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.rst.ready", 32'(ready[1]), 32'd0);
    check("abort.rst.data", rdata[1], 32'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready[1] !== 1'b0) seen++;
    end
    check("abort.noresp", 32'(seen), 32'd0);
    xfer1("w.lw30", 1'b1, 1'b0, 2'd2, 32'h30, 32'h0, 1'b0, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
